// File: rtl/bcd_count_ctrl_pkg.sv
// bcd_count_ctrl_pkg: shared types and constants for the BCD run controller.
// Provides the FSM state enum, BCD digit width/limit, and a BCD validity check.
package bcd_count_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam int              DIG_W   = 4;
    localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;

    // True when every one of the low ndig nibbles of v is a legal decimal digit.
    function automatic logic bcd_ok(input logic [31:0] v, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < ndig && v[4*i +: 4] > DIG_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_bcd_digit.sv
// bcd_digit: one synchronous decade digit (0..9) for a ripple carry chain.
// Ports: clk, rst_n (async low), clr, cin (advance), q (value), nxt (value
// after this edge), cout (this digit rolls 9->0 this edge).
module bcd_digit
    import bcd_count_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cin,
    output logic [DIG_W-1:0] q,
    output logic [DIG_W-1:0] nxt,
    output logic             cout
);

    assign cout = cin && (q == DIG_MAX);

    always_comb begin
        nxt = q;
        if (cin) begin
            nxt = (q == DIG_MAX) ? '0 : q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (cin) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: start/stop/clear run controller for an NDIG-digit BCD counter
// with prescaler and terminal count. Ports: CLK, RST_N, START, STOP, CLEAR,
// TC_VAL, COUNT, RUNNING, DONE, WRAP; LAP only when BCD_COUNT_LAP_EN is defined.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              CLEAR,
    input  logic [4*NDIG-1:0] TC_VAL,
    output logic [4*NDIG-1:0] COUNT,
    output logic              RUNNING,
    output logic              DONE,
    output logic              WRAP
`ifdef BCD_COUNT_LAP_EN
    ,
    output logic [4*NDIG-1:0] LAP
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t            state;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [NDIG:0]     carry;
    logic [4*NDIG-1:0] nxt;
    logic              tc_hit;

    assign tick     = (state == S_RUN) && (presc == PW'(PRESCALE - 1));
    assign carry[0] = tick;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit u_dig (
            .clk   (CLK),
            .rst_n (RST_N),
            .clr   (CLEAR),
            .cin   (carry[i]),
            .q     (COUNT[4*i +: 4]),
            .nxt   (nxt[4*i +: 4]),
            .cout  (carry[i+1])
        );
    end

    // Only an increment can land on the terminal count; invalid TC never hits.
    assign tc_hit = tick && bcd_ok(32'(TC_VAL), NDIG) && (nxt == TC_VAL);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            presc   <= '0;
            RUNNING <= 1'b0;
            DONE    <= 1'b0;
            WRAP    <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            if (CLEAR) begin
                state   <= S_IDLE;
                presc   <= '0;
                RUNNING <= 1'b0;
                DONE    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (START && !STOP) begin
                            state   <= S_RUN;
                            RUNNING <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (tick) begin
                            presc <= '0;
                            WRAP  <= carry[NDIG];
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (tc_hit) begin
                            state   <= S_DONE;
                            RUNNING <= 1'b0;
                            DONE    <= 1'b1;
                        end else if (STOP) begin
                            state   <= S_PAUSE;
                            RUNNING <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        if (START && !STOP) begin
                            state   <= S_RUN;
                            RUNNING <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                endcase
            end
        end
    end

`ifdef BCD_COUNT_LAP_EN
    // Lap capture takes COUNT as it was before this edge's increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LAP <= '0;
        end else if (CLEAR) begin
            LAP <= '0;
        end else if (state == S_RUN && START && !STOP) begin
            LAP <= COUNT;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed bench for bcd_count_ctrl (NDIG=2, PRESCALE=3)
// with a decimal-integer reference model compared on every falling edge.
module tb_bcd_count_ctrl;

    localparam int NDIG = 2;
    localparam int PRESCALE = 3;

    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE = 3;

    logic              CLK;
    logic              RST_N;
    logic              START;
    logic              STOP;
    logic              CLEAR;
    logic [4*NDIG-1:0] TC_VAL;
    logic [4*NDIG-1:0] COUNT;
    logic              RUNNING;
    logic              DONE;
    logic              WRAP;
`ifdef BCD_COUNT_LAP_EN
    logic [4*NDIG-1:0] LAP;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int wrap_seen = 0;

    int m_st = M_IDLE;
    int m_cnt = 0;
    int m_pre = 0;
    int m_lap = 0;
    bit m_wrap = 0;

    bcd_count_ctrl #(
        .NDIG     (NDIG),
        .PRESCALE (PRESCALE)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .STOP    (STOP),
        .CLEAR   (CLEAR),
        .TC_VAL  (TC_VAL),
        .COUNT   (COUNT),
        .RUNNING (RUNNING),
        .DONE    (DONE),
        .WRAP    (WRAP)
`ifdef BCD_COUNT_LAP_EN
        ,
        .LAP     (LAP)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit tc_valid(input logic [4*NDIG-1:0] t);
        bit ok;
        ok = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (t[4*i +: 4] > 4'd9) ok = 0;
        end
        return ok;
    endfunction

    function automatic int tc_num(input logic [4*NDIG-1:0] t);
        int n;
        n = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            n = n * 10 + int'(t[4*i +: 4]);
        end
        return n;
    endfunction

    function automatic int full_scale();
        int m;
        m = 1;
        for (int i = 0; i < NDIG; i++) m = m * 10;
        return m - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit s, input bit p, input bit c);
        m_wrap = 0;
        if (c) begin
            m_st = M_IDLE;
            m_cnt = 0;
            m_pre = 0;
            m_lap = 0;
        end else begin
            case (m_st)
                M_IDLE: if (s && !p) m_st = M_RUN;
                M_RUN: begin
                    if (s && !p) m_lap = m_cnt;
                    if (m_pre == PRESCALE - 1) begin
                        m_pre = 0;
                        if (m_cnt == full_scale()) begin
                            m_cnt = 0;
                            m_wrap = 1;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                        if (tc_valid(TC_VAL) && m_cnt == tc_num(TC_VAL))
                            m_st = M_DONE;
                    end else begin
                        m_pre = m_pre + 1;
                    end
                    if (m_st == M_RUN && p) m_st = M_PAUSE;
                end
                M_PAUSE: if (s && !p) m_st = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_cnt = 0;
        m_pre = 0;
        m_lap = 0;
        m_wrap = 0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("count", 32'(COUNT), 32'(to_bcd(m_cnt)));
            chk("running", 32'(RUNNING), 32'(m_st == M_RUN));
            chk("done", 32'(DONE), 32'(m_st == M_DONE));
            chk("wrap", 32'(WRAP), 32'(m_wrap));
`ifdef BCD_COUNT_LAP_EN
            chk("lap", 32'(LAP), 32'(to_bcd(m_lap)));
`endif
            if (WRAP) wrap_seen++;
        end
    end

    task automatic cyc(input bit s, input bit p, input bit c);
        START = s;
        STOP = p;
        CLEAR = c;
        @(posedge CLK);
        model_step(s, p, c);
        #2;
        START = 0;
        STOP = 0;
        CLEAR = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        RST_N = 0;
        START = 0;
        STOP = 0;
        CLEAR = 0;
        TC_VAL = 8'h12;
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1;
        model_reset();
        chk_en = 1;
        #1;
        chk("rst_count", 32'(COUNT), 32'h0);
        chk("rst_running", 32'(RUNNING), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_wrap", 32'(WRAP), 32'h0);

        // Run to terminal count 12.
        cyc(1, 0, 0);
        #1 chk("start_running", 32'(RUNNING), 32'h1);
        idle(2);
        #1 chk("pre_first_inc", 32'(COUNT), 32'h00);
        idle(1);
        #1 chk("first_inc", 32'(COUNT), 32'h01);
        idle(40);
        #1 chk("tc_count", 32'(COUNT), 32'h12);
        chk("tc_done", 32'(DONE), 32'h1);
        chk("tc_running", 32'(RUNNING), 32'h0);
        cyc(1, 1, 0);
        #1 chk("done_hold", 32'(COUNT), 32'h12);

        // Pause at 05 with one prescaler cycle left.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(16);
        cyc(0, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0);
        #1 chk("pause_count", 32'(COUNT), 32'h05);
        chk("pause_running", 32'(RUNNING), 32'h0);
        cyc(1, 0, 0);
        #1 chk("resume_count", 32'(COUNT), 32'h05);
        idle(1);
        #1 chk("resume_inc", 32'(COUNT), 32'h06);

        // Invalid TC: free-run through full scale.
        TC_VAL = 8'hFF;
        cyc(0, 0, 1);
        wrap_seen = 0;
        cyc(1, 0, 0);
        idle(310);
        #1 chk("wrap_pulses", 32'(wrap_seen), 32'd1);
        chk("wrap_running", 32'(RUNNING), 32'h1);
        chk("wrap_count", 32'(COUNT), 32'h03);

        // All commands at once at 07.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(21);
        #1 chk("at07", 32'(COUNT), 32'h07);
        cyc(1, 1, 1);
        #1 chk("all_count", 32'(COUNT), 32'h00);
        chk("all_running", 32'(RUNNING), 32'h0);
        chk("all_done", 32'(DONE), 32'h0);
        idle(4);
        #1 chk("idle_hold", 32'(COUNT), 32'h00);

        // Asynchronous reset mid-run at 34.
        cyc(1, 0, 0);
        idle(102);
        #1 chk("at34", 32'(COUNT), 32'h34);
        RST_N = 0;
        model_reset();
        #1 chk("arst_count", 32'(COUNT), 32'h00);
        chk("arst_running", 32'(RUNNING), 32'h0);
        @(posedge CLK);
        #2 RST_N = 1;
        cyc(1, 0, 0);
        idle(3);
        #1 chk("restart", 32'(COUNT), 32'h01);

`ifdef BCD_COUNT_LAP_EN
        // Lap capture at 23.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(69);
        #1 chk("at23", 32'(COUNT), 32'h23);
        cyc(1, 0, 0);
        #1 chk("lap_val", 32'(LAP), 32'h23);
        chk("lap_count", 32'(COUNT), 32'h23);
        idle(2);
        #1 chk("lap_next", 32'(COUNT), 32'h24);
        cyc(0, 0, 1);
        #1 chk("lap_clear", 32'(LAP), 32'h00);
`endif

        idle(2);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
